// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: base opcodes, fetch FSM states and the opcode
// pre-classification used by the fetch stage.
package riscv_pkg;

  typedef enum logic [6:0] {
    OP_LOAD     = 7'b0000011,
    OP_MISC_MEM = 7'b0001111,
    OP_REG_IMM  = 7'b0010011,
    OP_AUIPC    = 7'b0010111,
    OP_STORE    = 7'b0100011,
    OP_REG_REG  = 7'b0110011,
    OP_LUI      = 7'b0110111,
    OP_BRANCH   = 7'b1100011,
    OP_JALR     = 7'b1100111,
    OP_JAL      = 7'b1101111,
    OP_SYSTEM   = 7'b1110011
  } opcode_t;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Only the core integer/memory/branch groups count as supported here.
  function automatic logic is_base_opcode(input logic [6:0] op);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_REG_IMM, OP_REG_REG, OP_LOAD, OP_STORE, OP_BRANCH: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/riscv_if_buffer.sv
// One-entry IF/ID output register: loads a fetched word, holds it while decode
// stalls, and drops it on a flush.
module riscv_if_buffer
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            load,
  input  logic [XLEN-1:0] load_pc,
  input  logic [31:0]     load_instr,
  input  logic            id_ready,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [31:0]     id_instr,
  output opcode_t         id_opcode,
  output logic            id_illegal
);

  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid   <= 1'b0;
      id_pc      <= '0;
      id_instr   <= NOP_INSTR;
      id_illegal <= 1'b0;
    end else if (flush) begin
      id_valid <= 1'b0;
    end else if (load) begin
      id_valid   <= 1'b1;
      id_pc      <= load_pc;
      id_instr   <= load_instr;
      id_illegal <= !is_base_opcode(load_instr[6:0]);
    end else if (id_ready) begin
      id_valid <= 1'b0;
    end
  end

  assign id_opcode = opcode_t'(id_instr[6:0]);

endmodule

// File: rtl/riscv_fetch_stage.sv
// RV32I instruction fetch: PC ownership, single-outstanding imem request
// channel, redirect/squash handling and the IF/ID output register.
module riscv_fetch_stage
  import riscv_pkg::*;
#(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [31:0]     id_instr,
  output opcode_t         id_opcode,
  output logic            id_illegal
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q;
  logic            accept;
  logic            rsp_load;
  logic            unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Only request when the output register is sure to be free on response.
  assign imem_req_valid = !rst && (state_q == S_REQ) && (!id_valid || id_ready);
  assign imem_req_addr  = pc_q;
  assign accept         = imem_req_valid && imem_req_ready;
  assign rsp_load       = (state_q == S_WAIT) && imem_rsp_valid && !redirect_valid;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (redirect_valid) begin
      pc_d = {redirect_pc[XLEN-1:2], 2'b00};
      case (state_q)
        S_REQ:   state_d = accept ? S_DRAIN : S_REQ;
        S_WAIT:  state_d = imem_rsp_valid ? S_REQ : S_DRAIN;
        // A drain still waiting for its response must keep waiting.
        S_DRAIN: state_d = imem_rsp_valid ? S_REQ : S_DRAIN;
        default: state_d = S_REQ;
      endcase
    end else begin
      case (state_q)
        S_REQ: begin
          if (accept) begin
            pc_d    = pc_q + XLEN'(4);
            state_d = S_WAIT;
          end
        end
        S_WAIT:  if (imem_rsp_valid) state_d = S_REQ;
        S_DRAIN: if (imem_rsp_valid) state_d = S_REQ;
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q    <= {RESET_PC[XLEN-1:2], 2'b00};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Address of the outstanding request, reported as id_pc on its response.
  always_ff @(posedge clk) begin
    if (accept) req_pc_q <= pc_q;
  end

  riscv_if_buffer #(
    .XLEN(XLEN)
  ) u_if_buffer (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .load      (rsp_load),
    .load_pc   (req_pc_q),
    .load_instr(imem_rsp_data),
    .id_ready  (id_ready),
    .id_valid  (id_valid),
    .id_pc     (id_pc),
    .id_instr  (id_instr),
    .id_opcode (id_opcode),
    .id_illegal(id_illegal)
  );

endmodule

// File: tb/tb_riscv_fetch_stage.sv
// Bench for riscv_fetch_stage: latency-programmable memory model plus a
// scoreboard of accepted fetches popped as decode consumes them.
module tb_riscv_fetch_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  opcode_t     id_opcode;
  logic        id_illegal;

  riscv_fetch_stage #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .id_valid      (id_valid),
    .id_ready      (id_ready),
    .id_pc         (id_pc),
    .id_instr      (id_instr),
    .id_opcode     (id_opcode),
    .id_illegal    (id_illegal)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [6:0] op;
    if (a == 32'h40) return 32'h0000_006F;
    if (a == 32'h44) return 32'h00A0_0093;
    case (a[4:2])
      3'd0: op = 7'h03;
      3'd1: op = 7'h13;
      3'd2: op = 7'h23;
      3'd3: op = 7'h33;
      3'd4: op = 7'h63;
      3'd5: op = 7'h6F;
      3'd6: op = 7'h37;
      default: op = 7'h73;
    endcase
    return {a[26:2], op};
  endfunction

  function automatic logic exp_illegal(input logic [31:0] w);
    logic [6:0] op;
    op = w[6:0];
    return !(op == 7'h03 || op == 7'h13 || op == 7'h23 || op == 7'h33 || op == 7'h63);
  endfunction

  // Memory model: one request at a time, response after lat cycles.
  int          lat = 1;
  logic        pend = 1'b0;
  logic [31:0] paddr = '0;
  int          cnt = 0;

  initial forever begin
    @(negedge clk);
    if (!rst && imem_req_valid && imem_req_ready) begin
      pend  = 1'b1;
      paddr = imem_req_addr;
      cnt   = lat;
    end
    @(posedge clk);
    #2;
    imem_rsp_valid = 1'b0;
    if (rst) pend = 1'b0;
    else if (pend) begin
      cnt--;
      if (cnt <= 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(paddr);
        pend           = 1'b0;
      end
    end
  end

  // Scoreboard monitor.
  logic [63:0] sb_q[$];
  logic [31:0] exp_pc = '0;
  int          n_pop = 0;
  logic [31:0] last_pop_pc = '0;
  logic        last_pop_illegal = 1'b0;
  logic [6:0]  last_pop_opcode = '0;
  logic        prev_stall = 1'b0;
  logic        prev_redir = 1'b0;
  logic [31:0] prev_pc = '0;
  logic [31:0] prev_instr = '0;

  initial forever begin
    logic [63:0] e;
    @(negedge clk);
    if (rst) begin
      sb_q.delete();
      exp_pc     = 32'h0;
      prev_stall = 1'b0;
      prev_redir = 1'b0;
    end else begin
      if (prev_redir) chk("flush_valid", id_valid, 0);
      if (prev_stall) begin
        chk("stall_valid", id_valid, 1);
        chk("stall_pc", id_pc, prev_pc);
        chk("stall_instr", id_instr, prev_instr);
      end
      if (id_valid && !id_ready) chk("stall_req", imem_req_valid, 0);
      if (imem_req_valid) chk("req_addr", imem_req_addr, exp_pc);
      if (id_valid && id_ready && !redirect_valid) begin
        if (sb_q.size() == 0) chk("spurious_valid", id_valid, 0);
        else begin
          e = sb_q.pop_front();
          chk("id_pc", id_pc, e[63:32]);
          chk("id_instr", id_instr, e[31:0]);
          chk("id_opcode", id_opcode, e[6:0]);
          chk("id_illegal", id_illegal, exp_illegal(e[31:0]));
          n_pop++;
          last_pop_pc      = id_pc;
          last_pop_illegal = id_illegal;
          last_pop_opcode  = id_opcode;
        end
      end
      if (imem_req_valid && imem_req_ready) begin
        sb_q.push_back({imem_req_addr, mem_word(imem_req_addr)});
        exp_pc = imem_req_addr + 32'd4;
      end
      if (redirect_valid) begin
        sb_q.delete();
        exp_pc = {redirect_pc[31:2], 2'b00};
      end
      prev_redir = redirect_valid;
      prev_stall = id_valid && !id_ready && !redirect_valid;
      prev_pc    = id_pc;
      prev_instr = id_instr;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pop(input string tag, input logic [31:0] a, input int bound);
    int   start;
    logic found;
    found = 1'b0;
    start = n_pop;
    for (int i = 0; i < bound; i++) begin
      step();
      if (n_pop != start && last_pop_pc == a) begin
        found = 1'b1;
        break;
      end
    end
    chk(tag, found, 1);
  endtask

  task automatic redirect_to(input logic [31:0] a);
    redirect_valid = 1'b1;
    redirect_pc    = a;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    logic got;
    int   start;

    // Reset state
    rst = 1'b1;
    repeat (3) step();
    @(negedge clk);
    chk("rst_id_valid", id_valid, 0);
    chk("rst_id_pc", id_pc, 0);
    chk("rst_id_instr", id_instr, 32'h0000_0013);
    chk("rst_id_illegal", id_illegal, 0);
    chk("rst_req_valid", imem_req_valid, 0);

    // Streaming fetch, k = 1, decode always ready
    lat = 1;
    imem_req_ready = 1'b1;
    id_ready = 1'b1;
    step();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      case (c)
        0: begin
          chk("c0_req_valid", imem_req_valid, 1);
          chk("c0_req_addr", imem_req_addr, 32'h0);
        end
        1: chk("c1_id_valid", id_valid, 0);
        2: begin
          chk("c2_id_valid", id_valid, 1);
          chk("c2_id_pc", id_pc, 32'h0);
          chk("c2_id_instr", id_instr, 32'h0000_0003);
          chk("c2_req_addr", imem_req_addr, 32'h4);
        end
        3: chk("c3_id_valid", id_valid, 0);
        4: begin
          chk("c4_id_valid", id_valid, 1);
          chk("c4_id_pc", id_pc, 32'h4);
          chk("c4_req_addr", imem_req_addr, 32'h8);
        end
        default: chk("c5_id_valid", id_valid, 0);
      endcase
    end
    @(posedge clk);
    #1;
    repeat (6) step();

    // Decode stall for 5 cycles
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (id_valid) begin
        got = 1'b1;
        break;
      end
      step();
    end
    chk("stall_found_valid", got, 1);
    id_ready = 1'b0;
    repeat (5) step();
    id_ready = 1'b1;
    repeat (4) step();

    // Redirect while a fetch is outstanding, response 3 cycles after accept
    lat = 3;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) begin
        got = 1'b1;
        break;
      end
    end
    chk("wait_accept_seen", got, 1);
    step();
    redirect_to(32'h100);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("drain_id_valid", id_valid, 0);
    end
    step();
    wait_pop("redir_wait_0x100", 32'h100, 30);

    // Redirect in the same cycle a request is accepted
    lat = 1;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (imem_req_valid) begin
        got = 1'b1;
        break;
      end
    end
    chk("req_for_redirect", got, 1);
    redirect_to(32'h203);
    wait_pop("redir_acc_0x200", 32'h200, 20);

    // Opcode classification
    redirect_to(32'h40);
    wait_pop("pop_0x40", 32'h40, 20);
    chk("jal_illegal", last_pop_illegal, 1);
    chk("jal_opcode", last_pop_opcode, 7'h6F);
    wait_pop("pop_0x44", 32'h44, 20);
    chk("addi_illegal", last_pop_illegal, 0);
    chk("addi_opcode", last_pop_opcode, 7'h13);

    // PC wrap
    redirect_to(32'hFFFF_FFFC);
    wait_pop("pop_wrap_hi", 32'hFFFF_FFFC, 20);
    wait_pop("pop_wrap_0", 32'h0, 20);

    // Random traffic with stalls, backpressure and redirects
    start = n_pop;
    for (int i = 0; i < 400; i++) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      id_ready       = ($urandom_range(0, 3) != 0);
      lat            = int'($urandom_range(1, 3));
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = $urandom;
      step();
    end
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    id_ready       = 1'b1;
    lat            = 1;
    chk("rand_progress", (n_pop - start) > 20, 1);

    // Reset in the middle of a fetch
    repeat (3) step();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    wait_pop("post_reset_0x0", 32'h0, 20);
    wait_pop("post_reset_0x4", 32'h4, 20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got %0d vectors expected completion", n_vec);
    $fatal(1);
  end

endmodule
